// File: rtl/regfile_multiport.sv
// Multi-port register file: NR registered read ports, one byte-enabled write port with
// write-through bypass, optional hardwired-zero entry 0, and a one-entry-per-cycle clear sequencer.
module regfile_multiport #(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int NR       = 2,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   output logic             busy,
   input  logic [NR*AW-1:0] rd_addr,
   output logic [NR*DW-1:0] rd_data,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [DW/8-1:0]  wr_be,
   input  logic [DW-1:0]    wr_data
);

   // state    | meaning
   // ST_CLEAR | sequencer writes 0 to entry clr_cnt each cycle; writes ignored, reads give 0
   // ST_IDLE  | normal read/write operation
   typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

   localparam int NB = DW / 8;

   state_t            state, state_nxt;
   logic [AW-1:0]     clr_cnt, clr_cnt_nxt;
   logic              clr_wr;
   logic              wr_in_range;
   logic              wr_zero;
   logic              wr_ok;
   logic [NR*DW-1:0]  rd_nxt;
   logic [DW-1:0]     mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         ST_CLEAR: begin
            if (clear) begin
               clr_cnt_nxt = '0;
            end else if (clr_cnt == AW'(DEPTH - 1)) begin
               state_nxt   = ST_IDLE;
               clr_cnt_nxt = '0;
            end else begin
               clr_cnt_nxt = clr_cnt + AW'(1);
            end
         end
         ST_IDLE: begin
            if (clear) begin
               state_nxt   = ST_CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      busy   = (state == ST_CLEAR);
      clr_wr = (state == ST_CLEAR);
   end

   // Widen by one bit so the compare stays meaningful when DEPTH is a power of two.
   assign wr_in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
   assign wr_zero     = (ZERO_REG != 0) && (wr_addr == '0);
   assign wr_ok       = wr_en && !busy && wr_in_range && !wr_zero;

   always_ff @(posedge clk) begin
      if (clr_wr) begin
         mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          in_range;
      logic          hit;
      logic [DW-1:0] old_val;
      logic [DW-1:0] merged;

      assign ra       = rd_addr[i*AW +: AW];
      assign in_range = ({1'b0, ra} < (AW+1)'(DEPTH));
      assign old_val  = in_range ? mem[ra] : '0;
      assign hit      = wr_ok && (wr_addr == ra);

      // Same-edge write merges into the read so the port never returns stale bytes.
      always_comb begin
         merged = old_val;
         if (hit) begin
            for (int b = 0; b < NB; b++) begin
               if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end

      assign rd_nxt[i*DW +: DW] = ((ZERO_REG != 0) && (ra == '0)) ? '0 : merged;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rd_data <= '0;
      else if (busy) rd_data <= '0;
      else           rd_data <= rd_nxt;
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default 32x32/2-port instance plus a 24-entry 3-port
// instance for out-of-range addressing and reset-during-clear.
module tb_regfile_multiport;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        busy;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;

   logic        rst2;
   logic        clear2;
   logic        busy2;
   logic [14:0] rd_addr2;
   logic [95:0] rd_data2;
   logic        wr_en2;
   logic [4:0]  wr_addr2;
   logic [3:0]  wr_be2;
   logic [31:0] wr_data2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_multiport dut (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data)
   );

   regfile_multiport #(.DW(32), .DEPTH(24), .NR(3), .ZERO_REG(1)) dut24 (
      .clk(clk), .rst(rst2), .clear(clear2), .busy(busy2),
      .rd_addr(rd_addr2), .rd_data(rd_data2),
      .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_be(wr_be2), .wr_data(wr_data2)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      int n;
      logic rd_zero_ok;

      rst = 1'b1; clear = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rst2 = 1'b1; clear2 = 1'b0; rd_addr2 = '0; wr_en2 = 1'b0; wr_addr2 = '0; wr_be2 = '0; wr_data2 = '0;
      repeat (3) tick();
      chk("reset_busy", busy, 1'b1);
      chk("reset_rd_data", rd_data, 64'h0);

      // 1: busy for exactly 32 cycles after release, reads zero meanwhile
      set_rd(5'd7, 5'd31);
      rst = 1'b0; rst2 = 1'b0;
      n = 0; rd_zero_ok = 1'b1;
      while (busy && n < 100) begin
         if (rd_data != 64'h0) rd_zero_ok = 1'b0;
         tick();
         n++;
      end
      chk("init_busy_cycles", n, 32);
      chk("init_rd_zero_while_busy", rd_zero_ok, 1'b1);
      for (int a = 0; a < 32; a++) begin
         set_rd(a[4:0], 5'(31 - a));
         tick();
         chk($sformatf("init_zero_p0_%0d", a), rd_data[31:0], 32'h0);
         chk($sformatf("init_zero_p1_%0d", a), rd_data[63:32], 32'h0);
      end

      // 2: full write then dual-port read
      write(5'd5, 4'hF, 32'hDEADBEEF);
      set_rd(5'd5, 5'd5);
      tick();
      chk("wr5_p0", rd_data[31:0], 32'hDEADBEEF);
      chk("wr5_p1", rd_data[63:32], 32'hDEADBEEF);

      // 3: byte-enable bypass on the same edge, then the stored value
      set_rd(5'd5, 5'd6);
      write(5'd5, 4'b0010, 32'h0000AA00);
      chk("bypass_merge", rd_data[31:0], 32'hDEADAAEF);
      chk("bypass_other_port", rd_data[63:32], 32'h0);
      tick();
      chk("merged_stored", rd_data[31:0], 32'hDEADAAEF);
      write(5'd5, 4'h0, 32'hFFFFFFFF);
      chk("be_zero_noop_bypass", rd_data[31:0], 32'hDEADAAEF);
      write(5'd6, 4'b1001, 32'h11223344);
      chk("partial_write_fresh", rd_data[63:32], 32'h11000044);

      // 4: hardwired zero entry
      set_rd(5'd0, 5'd0);
      write(5'd0, 4'hF, 32'h12345678);
      chk("zero_same_edge", rd_data[31:0], 32'h0);
      tick();
      chk("zero_next_cycle", rd_data[63:32], 32'h0);

      // 5: fill, double clear, writes while busy dropped
      for (int a = 1; a < 32; a++) write(a[4:0], 4'hF, 32'(a));
      set_rd(5'd7, 5'd31);
      tick();
      chk("fill_7", rd_data[31:0], 32'd7);
      chk("fill_31", rd_data[63:32], 32'd31);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clear1_busy", busy, 1'b1);
      repeat (9) tick();
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clear2_busy", busy, 1'b1);
      wr_en = 1'b1; wr_addr = 5'd3; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
      n = 0; rd_zero_ok = 1'b1;
      while (busy && n < 100) begin
         if (rd_data != 64'h0) rd_zero_ok = 1'b0;
         tick();
         n++;
      end
      wr_en = 1'b0;
      chk("clear2_busy_cycles", n, 32);
      chk("clear_rd_zero_while_busy", rd_zero_ok, 1'b1);
      for (int a = 0; a < 32; a++) begin
         set_rd(a[4:0], 5'(31 - a));
         tick();
         chk($sformatf("cleared_p0_%0d", a), rd_data[31:0], 32'h0);
         chk($sformatf("cleared_p1_%0d", a), rd_data[63:32], 32'h0);
      end

      // clear and write on the same edge: the clear wins
      write(5'd9, 4'hF, 32'hA5A5A5A5);
      set_rd(5'd9, 5'd9);
      tick();
      chk("pre_clear_9", rd_data[31:0], 32'hA5A5A5A5);
      clear = 1'b1;
      write(5'd9, 4'hF, 32'h5A5A5A5A);
      clear = 1'b0;
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      chk("clear_wr_busy_cycles", n, 32);
      tick();
      chk("clear_wipes_write", rd_data[31:0], 32'h0);

      // 6: DEPTH=24, NR=3 out-of-range and reset mid-clear
      chk("d24_idle", busy2, 1'b0);
      wr_en2 = 1'b1; wr_addr2 = 5'd23; wr_be2 = 4'hF; wr_data2 = 32'hCAFEF00D;
      tick();
      rd_addr2 = {5'd30, 5'd23, 5'd24};
      wr_addr2 = 5'd30; wr_data2 = 32'h11111111;
      tick();
      wr_en2 = 1'b0;
      chk("d24_oor_bypass", rd_data2[95:64], 32'h0);
      chk("d24_last_entry", rd_data2[63:32], 32'hCAFEF00D);
      chk("d24_oor_read24", rd_data2[31:0], 32'h0);
      tick();
      chk("d24_oor_stored", rd_data2[95:64], 32'h0);
      clear2 = 1'b1; tick(); clear2 = 1'b0;
      repeat (5) tick();
      rst2 = 1'b1;
      #1;
      chk("d24_rst_busy", busy2, 1'b1);
      chk("d24_rst_rd_zero", rd_data2, 96'h0);
      repeat (2) tick();
      rst2 = 1'b0;
      n = 0;
      while (busy2 && n < 100) begin tick(); n++; end
      chk("d24_rst_busy_cycles", n, 24);
      rd_addr2 = {5'd1, 5'd23, 5'd12};
      tick();
      chk("d24_cleared_23", rd_data2[63:32], 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
